// File: rtl/bram_param_clr.sv
// Dual-port block RAM with a hardware clear sweep, per-port read enables with
// aligned valid strobes, selectable read-during-write and optional output stage.
module bram_param_clr #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    DEPTH        = 1024,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = {DATA_WIDTH{1'b0}},
  parameter bit                    WR_FIRST     = 1'b0,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_start,
  output logic                  clr_busy,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  douta_vld,
  input  logic                  enb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_vld
);

  localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [IDX_W-1:0]        clr_cnt_r;
  logic [IDX_W-1:0]        clr_cnt_nxt_s;
  logic                    clr_busy_r;
  logic [DATA_WIDTH-1:0]   mem_r [0:DEPTH-1];

  logic                    run_s;
  logic                    a_in_range_s;
  logic                    b_in_range_s;
  logic [IDX_W-1:0]        a_idx_s;
  logic [IDX_W-1:0]        b_idx_s;
  logic                    wr_a_s;
  logic                    wr_b_s;
  logic                    rd_a_s;
  logic                    rd_b_s;
  logic [DATA_WIDTH-1:0]   rdat_a_s;
  logic [DATA_WIDTH-1:0]   rdat_b_s;

  logic [DATA_WIDTH-1:0]   douta_s1_r;
  logic [DATA_WIDTH-1:0]   doutb_s1_r;
  logic                    douta_vld_s1_r;
  logic                    doutb_vld_s1_r;

  // Index bits are only used once the address is known to be in range.
  assign run_s        = (state_r == ST_RUN);
  assign a_in_range_s = ({1'b0, addra} < DEPTH_EXT);
  assign b_in_range_s = ({1'b0, addrb} < DEPTH_EXT);
  assign a_idx_s      = addra[IDX_W-1:0];
  assign b_idx_s      = addrb[IDX_W-1:0];

  // Port B wins a same-address write collision, so A is dropped.
  assign wr_b_s = run_s && web && b_in_range_s;
  assign wr_a_s = run_s && wea && a_in_range_s && !(web && (addra == addrb));
  assign rd_a_s = run_s && ena;
  assign rd_b_s = run_s && enb;

  // Sweep sequencer next state: walk every word once, then serve the ports.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == LAST_IDX) begin
          state_nxt_s   = ST_RUN;
          clr_cnt_nxt_s = {IDX_W{1'b0}};
        end else begin
          state_nxt_s   = ST_CLEAR;
          clr_cnt_nxt_s = clr_cnt_r + IDX_W'(1);
        end
      end
      ST_RUN: begin
        if (clr_start) begin
          state_nxt_s   = ST_CLEAR;
          clr_cnt_nxt_s = {IDX_W{1'b0}};
        end else begin
          state_nxt_s   = ST_RUN;
        end
      end
      default: begin
        state_nxt_s   = ST_CLEAR;
        clr_cnt_nxt_s = {IDX_W{1'b0}};
      end
    endcase
  end

  // Sequencer state, sweep counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_CLEAR;
      clr_cnt_r  <= {IDX_W{1'b0}};
      clr_busy_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      clr_cnt_r  <= clr_cnt_nxt_s;
      clr_busy_r <= (state_nxt_s == ST_CLEAR);
    end
  end

  assign clr_busy = clr_busy_r;

  // Array writes: sweep word while clearing, otherwise the accepted port writes.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == ST_CLEAR)) begin
      mem_r[clr_cnt_r] <= INIT_VALUE;
    end
    if (!rst && wr_a_s) begin
      mem_r[a_idx_s] <= dina;
    end
    if (!rst && wr_b_s) begin
      mem_r[b_idx_s] <= dinb;
    end
  end

  // Port A read word; write-first forwards whatever this edge stores.
  always_comb begin
    rdat_a_s = {DATA_WIDTH{1'b0}};
    if (!a_in_range_s) begin
      rdat_a_s = {DATA_WIDTH{1'b0}};
    end else if (WR_FIRST && wr_b_s && (addrb == addra)) begin
      rdat_a_s = dinb;
    end else if (WR_FIRST && wr_a_s) begin
      rdat_a_s = dina;
    end else begin
      rdat_a_s = mem_r[a_idx_s];
    end
  end

  // Port B read word, mirroring port A.
  always_comb begin
    rdat_b_s = {DATA_WIDTH{1'b0}};
    if (!b_in_range_s) begin
      rdat_b_s = {DATA_WIDTH{1'b0}};
    end else if (WR_FIRST && wr_b_s) begin
      rdat_b_s = dinb;
    end else if (WR_FIRST && wr_a_s && (addra == addrb)) begin
      rdat_b_s = dina;
    end else begin
      rdat_b_s = mem_r[b_idx_s];
    end
  end

  // First read stage; data holds whenever no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      douta_s1_r     <= {DATA_WIDTH{1'b0}};
      doutb_s1_r     <= {DATA_WIDTH{1'b0}};
      douta_vld_s1_r <= 1'b0;
      doutb_vld_s1_r <= 1'b0;
    end else begin
      douta_vld_s1_r <= rd_a_s;
      doutb_vld_s1_r <= rd_b_s;
      if (rd_a_s) begin
        douta_s1_r <= rdat_a_s;
      end
      if (rd_b_s) begin
        doutb_s1_r <= rdat_b_s;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] douta_s2_r;
      logic [DATA_WIDTH-1:0] doutb_s2_r;
      logic                  douta_vld_s2_r;
      logic                  doutb_vld_s2_r;

      // Output stage keeps advancing during a sweep so earlier reads finish.
      always_ff @(posedge clk) begin
        if (rst) begin
          douta_s2_r     <= {DATA_WIDTH{1'b0}};
          doutb_s2_r     <= {DATA_WIDTH{1'b0}};
          douta_vld_s2_r <= 1'b0;
          doutb_vld_s2_r <= 1'b0;
        end else begin
          douta_vld_s2_r <= douta_vld_s1_r;
          doutb_vld_s2_r <= doutb_vld_s1_r;
          if (douta_vld_s1_r) begin
            douta_s2_r <= douta_s1_r;
          end
          if (doutb_vld_s1_r) begin
            doutb_s2_r <= doutb_s1_r;
          end
        end
      end

      assign douta     = douta_s2_r;
      assign doutb     = doutb_s2_r;
      assign douta_vld = douta_vld_s2_r;
      assign doutb_vld = doutb_vld_s2_r;
    end else begin : g_lat1
      assign douta     = douta_s1_r;
      assign doutb     = doutb_s1_r;
      assign douta_vld = douta_vld_s1_r;
      assign doutb_vld = doutb_vld_s1_r;
    end
  endgenerate

endmodule

// File: tb/tb_bram_param_clr.sv
// Drives two RAM builds (read-first/latency 1 and write-first/latency 2) with
// the same stimulus and checks both against an array-and-queue memory model.
module tb_bram_param_clr;

  localparam int          DEP  = 16;
  localparam logic [15:0] INIT = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_start = 1'b0;
  logic        ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
  logic [4:0]  addra = 5'd0, addrb = 5'd0;
  logic [15:0] dina = 16'h0, dinb = 16'h0;

  logic        busy0, busy1, va0, vb0, va1, vb1;
  logic [15:0] douta0, doutb0, douta1, doutb1;

  always #5 clk = ~clk;

  bram_param_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(DEP), .INIT_VALUE(INIT),
                   .WR_FIRST(1'b0), .READ_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(busy0),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0), .douta_vld(va0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0), .doutb_vld(vb0));

  bram_param_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(DEP), .INIT_VALUE(INIT),
                   .WR_FIRST(1'b1), .READ_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(busy1),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .douta_vld(va1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .doutb_vld(vb1));

  typedef struct {
    int          due;
    logic [15:0] d;
  } rd_t;

  // Streams: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
  rd_t         pq [4][$];
  logic [15:0] mem_m [DEP];
  logic [15:0] last_m [4];
  bit          evld_m [4];
  bit          in_clear_m = 1'b1;
  int          ptr_m = 0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          n;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_rd(input int k, input int due, input logic [15:0] v);
    rd_t e;
    e.due = due;
    e.d   = v;
    pq[k].push_back(e);
  endtask

  // Apply the rules of one clock edge to the model using the held inputs.
  task automatic model_edge();
    logic [15:0] oldm [DEP];
    logic [15:0] v_old, v_new;
    int ia, ib;
    ia = int'(addra);
    ib = int'(addrb);
    if (rst) begin
      in_clear_m = 1'b1;
      ptr_m = 0;
      for (int k = 0; k < 4; k++) begin
        pq[k].delete();
        last_m[k] = 16'h0;
        evld_m[k] = 1'b0;
      end
    end else begin
      if (in_clear_m) begin
        mem_m[ptr_m] = INIT;
        ptr_m++;
        if (ptr_m == DEP) in_clear_m = 1'b0;
      end else begin
        oldm = mem_m;
        if (wea && ia < DEP) mem_m[ia] = dina;
        if (web && ib < DEP) mem_m[ib] = dinb;
        if (ena) begin
          v_old = 16'h0; v_new = 16'h0;
          if (ia < DEP) begin v_old = oldm[ia]; v_new = mem_m[ia]; end
          push_rd(0, cyc, v_old);
          push_rd(2, cyc + 1, v_new);
        end
        if (enb) begin
          v_old = 16'h0; v_new = 16'h0;
          if (ib < DEP) begin v_old = oldm[ib]; v_new = mem_m[ib]; end
          push_rd(1, cyc, v_old);
          push_rd(3, cyc + 1, v_new);
        end
        if (clr_start) begin
          in_clear_m = 1'b1;
          ptr_m = 0;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
          last_m[k] = pq[k][0].d;
          evld_m[k] = 1'b1;
          void'(pq[k].pop_front());
        end else begin
          evld_m[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    model_edge();
    chk("busy0", {15'b0, busy0}, {15'b0, in_clear_m});
    chk("busy1", {15'b0, busy1}, {15'b0, in_clear_m});
    chk("douta0", douta0, last_m[0]);
    chk("doutb0", doutb0, last_m[1]);
    chk("douta1", douta1, last_m[2]);
    chk("doutb1", doutb1, last_m[3]);
    chk("va0", {15'b0, va0}, {15'b0, evld_m[0]});
    chk("vb0", {15'b0, vb0}, {15'b0, evld_m[1]});
    chk("va1", {15'b0, va1}, {15'b0, evld_m[2]});
    chk("vb1", {15'b0, vb1}, {15'b0, evld_m[3]});
  endtask

  task automatic idle();
    ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0; clr_start = 1'b0;
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (busy0 && cnt < 64) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) mem_m[i] = 16'h0;
    for (int k = 0; k < 4; k++) begin last_m[k] = 16'h0; evld_m[k] = 1'b0; end

    // Reset, then a sweep with port traffic that must be ignored.
    repeat (3) tick();
    rst = 1'b0;
    wea = 1'b1; addra = 5'd3; dina = 16'h1234; ena = 1'b1; enb = 1'b1; addrb = 5'd3;
    wait_clear(n);
    chk("clr_len", 16'(n), 16'd16);
    idle();

    // Every word reads back the sweep value.
    for (int a = 0; a < DEP; a++) begin
      ena = 1'b1; addra = 5'(a); enb = 1'b1; addrb = 5'(DEP - 1 - a);
      tick();
      chk("init_a0", douta0, INIT);
      chk("init_va0", {15'b0, va0}, 16'd1);
    end
    idle();
    repeat (2) tick();

    // Same-address write collision.
    wea = 1'b1; web = 1'b1; addra = 5'd5; addrb = 5'd5; dina = 16'h1111; dinb = 16'h2222;
    tick();
    idle();
    ena = 1'b1; addra = 5'd5;
    tick();
    chk("coll_a0", douta0, 16'h2222);
    idle();
    tick();
    chk("coll_a1", douta1, 16'h2222);

    // Read-during-write from the opposite port.
    wea = 1'b1; addra = 5'd7; dina = 16'h00FF;
    tick();
    wea = 1'b1; addra = 5'd7; dina = 16'h0F0F; enb = 1'b1; addrb = 5'd7;
    tick();
    chk("rdw_b0", doutb0, 16'h00FF);
    idle();
    tick();
    chk("rdw_b1", doutb1, 16'h0F0F);

    // Back-to-back reads through the two-stage build.
    for (int i = 0; i < 3; i++) begin
      web = 1'b1; addrb = 5'(i); dinb = 16'h1000 | 16'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      ena = 1'b1; addra = 5'(i);
      tick();
      if (i == 0) begin
        chk("lat_v_first", {15'b0, va1}, 16'd0);
      end else begin
        chk("lat_d", douta1, 16'h1000 | 16'(i - 1));
        chk("lat_v", {15'b0, va1}, 16'd1);
      end
    end
    idle();
    tick();
    chk("lat_d_last", douta1, 16'h1002);
    chk("lat_v_last", {15'b0, va1}, 16'd1);
    tick();
    chk("lat_v_end", {15'b0, va1}, 16'd0);
    chk("lat_hold", douta1, 16'h1002);

    // Out-of-range read returns zero with a strobe; write is dropped.
    ena = 1'b1; addra = 5'd20; web = 1'b1; addrb = 5'd20; dinb = 16'hBEEF;
    tick();
    chk("oor_a0", douta0, 16'h0);
    chk("oor_va0", {15'b0, va0}, 16'd1);
    idle();
    tick();

    // Randomised traffic with occasional re-clear and reset.
    for (int i = 0; i < 400; i++) begin
      ena = 1'($urandom_range(1, 0));
      wea = 1'($urandom_range(1, 0));
      enb = 1'($urandom_range(1, 0));
      web = 1'($urandom_range(1, 0));
      addra = 5'($urandom_range(31, 0));
      if ($urandom_range(3, 0) == 0) addrb = addra;
      else addrb = 5'($urandom_range(31, 0));
      dina = 16'($urandom);
      dinb = 16'($urandom);
      clr_start = ($urandom_range(63, 0) == 0);
      rst = ($urandom_range(127, 0) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    wait_clear(n);
    tick();

    // Fill, re-clear, reset mid-sweep, and confirm a full restart.
    for (int a = 0; a < DEP; a++) begin
      wea = 1'b1; addra = 5'(a); dina = 16'hFFFF;
      tick();
    end
    idle();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("reclr_busy", {15'b0, busy0}, 16'd1);
    for (int s = 0; s < 8; s++) begin
      clr_start = (s == 3);
      tick();
    end
    clr_start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear(n);
    chk("reclr_len", 16'(n), 16'd16);
    for (int a = 0; a < DEP; a++) begin
      ena = 1'b1; addra = 5'(a); enb = 1'b1; addrb = 5'(a);
      tick();
      chk("reclr_a0", douta0, INIT);
    end
    idle();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
